id_operand_stage: RTL and testbench

- Decode/operand-fetch stage of the Mini-RISC-V pipeline, directly upstream of the EX stage and wrapped around the register file's read ports.
- Accepts fetched instructions over a valid/ready handshake and drives the rs1/rs2 read addresses to the register file.
- Applies WB-to-ID bypass and load-use hazard stalls.
- Registers the instruction, PC and resolved operands into the ID/EX pipeline register, presented to EX over a second valid/ready handshake.

---
 rtl/minirv_pkg.sv | 61 ++++++
 rtl/id_hazard_unit.sv | 49 ++++
 rtl/id_operand_stage.sv | 111 +++++++++++
 tb/tb_id_operand_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minirv_pkg.sv
// Shared Mini-RISC-V constants, opcode map, ID/EX payload type and field helpers.
package minirv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG_W = 5;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0] OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] JALR   = 7'b1100111;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // Which register fields an opcode actually reads or writes.
  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } reg_use_t;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [NREG_W-1:0] rd;
  } idex_t;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [ILEN-1:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [NREG_W-1:0] get_rs1(input logic [ILEN-1:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [NREG_W-1:0] get_rs2(input logic [ILEN-1:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [NREG_W-1:0] get_rd(input logic [ILEN-1:0] instr);
    return instr[11:7];
  endfunction

  function automatic reg_use_t decode_use(input logic [OPC_W-1:0] opcode);
    reg_use_t u;
    u.uses_rs1  = !(opcode inside {LUI, AUIPC, JAL});
    u.uses_rs2  = opcode inside {OP, STORE, BRANCH};
    u.writes_rd = !(opcode inside {STORE, BRANCH});
    return u;
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Register-usage decode and ID stall generation (load-use, plus WB-write hazard
// when ID_WB_BYPASS_EN is not defined).
module id_hazard_unit
  import minirv_pkg::*;
(
  input  logic              if_valid,
  input  logic [OPC_W-1:0]  if_opcode,
  input  logic [NREG_W-1:0] if_rs1,
  input  logic [NREG_W-1:0] if_rs2,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [NREG_W-1:0] ex_rd,
  input  logic              wb_regwrite,
  input  logic [NREG_W-1:0] wb_adr_rd,
  output logic              uses_rs1_c,
  output logic              uses_rs2_c,
  output logic              writes_rd_c,
  output logic              wb_hit1_c,
  output logic              wb_hit2_c,
  output logic              stall_c
);

  reg_use_t use_c;
  logic     luse_c;
  logic     wb_haz_c;

  assign use_c       = decode_use(if_opcode);
  assign uses_rs1_c  = use_c.uses_rs1;
  assign uses_rs2_c  = use_c.uses_rs2;
  assign writes_rd_c = use_c.writes_rd;

  // WB destination matches a source field; x0 is never a real producer.
  assign wb_hit1_c = wb_regwrite && (wb_adr_rd != '0) && (wb_adr_rd == if_rs1);
  assign wb_hit2_c = wb_regwrite && (wb_adr_rd != '0) && (wb_adr_rd == if_rs2);

  assign luse_c = ex_valid && (ex_opcode == LOAD) && (ex_rd != '0) &&
                  ((uses_rs1_c && (if_rs1 == ex_rd)) ||
                   (uses_rs2_c && (if_rs2 == ex_rd)));

`ifdef ID_WB_BYPASS_EN
  assign wb_haz_c = 1'b0;
`else
  // Without the bypass mux, wait one cycle so the regfile write lands first.
  assign wb_haz_c = (uses_rs1_c && wb_hit1_c) || (uses_rs2_c && wb_hit2_c);
`endif

  assign stall_c = if_valid && (luse_c || wb_haz_c);

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: regfile read, hazard stall, ID/EX register.
// Optional WB-to-ID bypass mux enabled by ID_WB_BYPASS_EN.
module id_operand_stage
  import minirv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ILEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic [NREG_W-1:0] adr_rs1,
  output logic [NREG_W-1:0] adr_rs2,
  input  logic [XLEN-1:0]   dout_rs1,
  input  logic [XLEN-1:0]   dout_rs2,
  input  logic              wb_regwrite,
  input  logic [NREG_W-1:0] wb_adr_rd,
  input  logic [XLEN-1:0]   wb_din_rd,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [ILEN-1:0]   ex_instr,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [NREG_W-1:0] ex_rd
);

  idex_t             ex_q;
  logic              ex_valid_q;
  logic              uses_rs1_c;
  logic              uses_rs2_c;
  logic              writes_rd_c;
  logic              wb_hit1_c;
  logic              wb_hit2_c;
  logic              stall_c;
  logic              accept_c;
  logic [XLEN-1:0]   rs1_val_c;
  logic [XLEN-1:0]   rs2_val_c;
  logic [NREG_W-1:0] rd_c;

  assign adr_rs1 = get_rs1(if_instr);
  assign adr_rs2 = get_rs2(if_instr);

  id_hazard_unit u_hazard (
    .if_valid    (if_valid),
    .if_opcode   (get_opcode(if_instr)),
    .if_rs1      (adr_rs1),
    .if_rs2      (adr_rs2),
    .ex_valid    (ex_valid_q),
    .ex_opcode   (get_opcode(ex_q.instr)),
    .ex_rd       (ex_q.rd),
    .wb_regwrite (wb_regwrite),
    .wb_adr_rd   (wb_adr_rd),
    .uses_rs1_c  (uses_rs1_c),
    .uses_rs2_c  (uses_rs2_c),
    .writes_rd_c (writes_rd_c),
    .wb_hit1_c   (wb_hit1_c),
    .wb_hit2_c   (wb_hit2_c),
    .stall_c     (stall_c)
  );

  assign if_ready = (!ex_valid_q || ex_ready) && !stall_c && !flush;
  assign accept_c = if_valid && if_ready;

  // Operand select; x0 is forced to zero regardless of what WB presents.
  always_comb begin
    rs1_val_c = dout_rs1;
    rs2_val_c = dout_rs2;
`ifdef ID_WB_BYPASS_EN
    if (wb_hit1_c) rs1_val_c = wb_din_rd;
    if (wb_hit2_c) rs2_val_c = wb_din_rd;
`endif
    if (adr_rs1 == '0) rs1_val_c = '0;
    if (adr_rs2 == '0) rs2_val_c = '0;
  end

`ifndef ID_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_din_rd, wb_hit1_c, wb_hit2_c, uses_rs1_c, uses_rs2_c};
`else
  logic unused_use;
  assign unused_use = ^{uses_rs1_c, uses_rs2_c};
`endif

  assign rd_c = writes_rd_c ? get_rd(if_instr) : '0;

  // ID/EX register: flush wins, then accept, then drain into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '{instr: NOP, pc: '0, rs1_val: '0, rs2_val: '0, rd: '0};
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept_c) begin
      ex_valid_q <= 1'b1;
      ex_q       <= '{instr: if_instr, pc: if_pc, rs1_val: rs1_val_c,
                      rs2_val: rs2_val_c, rd: rd_c};
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_instr   = ex_q.instr;
  assign ex_pc      = ex_q.pc;
  assign ex_rs1_val = ex_q.rs1_val;
  assign ex_rs2_val = ex_q.rs2_val;
  assign ex_rd      = ex_q.rd;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with a cycle-level reference model and regfile.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  adr_rs1;
  logic [4:0]  adr_rs2;
  logic [31:0] dout_rs1;
  logic [31:0] dout_rs2;
  logic        wb_regwrite;
  logic [4:0]  wb_adr_rd;
  logic [31:0] wb_din_rd;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .adr_rs1(adr_rs1), .adr_rs2(adr_rs2), .dout_rs1(dout_rs1), .dout_rs2(dout_rs2),
    .wb_regwrite(wb_regwrite), .wb_adr_rd(wb_adr_rd), .wb_din_rd(wb_din_rd),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd)
  );

  // Register file: combinational read, write on the WB edge, x0 hard-wired.
  logic [31:0] rf [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h0101_0101;
      rf[3] <= 32'h0000_0011;
    end else if (wb_regwrite && wb_adr_rd != 5'd0) begin
      rf[wb_adr_rd] <= wb_din_rd;
    end
  end
  assign dout_rs1 = rf[adr_rs1];
  assign dout_rs2 = rf[adr_rs2];

  // Reference model state: what EX must see.
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_rs1, m_rs2;
  logic [4:0]  m_rd;

  // Returns {reads rs1, reads rs2, writes rd}.
  function automatic logic [2:0] m_fields(input logic [6:0] opc);
    case (opc)
      7'b0110111, 7'b0010111, 7'b1101111: return 3'b001;  // LUI AUIPC JAL
      7'b0110011:                         return 3'b111;  // OP
      7'b0100011, 7'b1100011:             return 3'b110;  // STORE BRANCH
      default:                            return 3'b101;
    endcase
  endfunction

  function automatic logic m_if_ready();
    logic [2:0] f;
    logic [4:0] s1, s2;
    logic       hz;
    f  = m_fields(if_instr[6:0]);
    s1 = if_instr[19:15];
    s2 = if_instr[24:20];
    hz = m_valid && m_instr[6:0] == 7'b0000011 && m_rd != 5'd0 &&
         ((f[2] && s1 == m_rd) || (f[1] && s2 == m_rd));
`ifndef ID_WB_BYPASS_EN
    if (wb_regwrite && wb_adr_rd != 5'd0 &&
        ((f[2] && wb_adr_rd == s1) || (f[1] && wb_adr_rd == s2))) hz = 1'b1;
`endif
    return (!m_valid || ex_ready) && !(if_valid && hz) && !flush;
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (wb_regwrite && wb_adr_rd == rs) return wb_din_rd;
`endif
    return rf[rs];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_instr <= 32'h0000_0013;
      m_pc    <= 32'h0;
      m_rs1   <= 32'h0;
      m_rs2   <= 32'h0;
      m_rd    <= 5'd0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (if_valid && m_if_ready()) begin
      m_valid <= 1'b1;
      m_instr <= if_instr;
      m_pc    <= if_pc;
      m_rs1   <= m_operand(if_instr[19:15]);
      m_rs2   <= m_operand(if_instr[24:20]);
      m_rd    <= m_fields(if_instr[6:0]) == 3'b110 ? 5'd0 : if_instr[11:7];
    end else if (ex_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_if_ready", 32'(if_ready), 32'(m_if_ready()));
      chk("m_adr_rs1", 32'(adr_rs1), 32'(if_instr[19:15]));
      chk("m_adr_rs2", 32'(adr_rs2), 32'(if_instr[24:20]));
      chk("m_ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("m_ex_instr", ex_instr, m_instr);
      chk("m_ex_pc", ex_pc, m_pc);
      chk("m_ex_rs1", ex_rs1_val, m_rs1);
      chk("m_ex_rs2", ex_rs2_val, m_rs2);
      chk("m_ex_rd", 32'(ex_rd), 32'(m_rd));
    end
  end

  task automatic apply(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic er, input logic wbw, input logic [4:0] wba,
                       input logic [31:0] wbd, input logic fl);
    if_valid    = v;
    if_instr    = instr;
    if_pc       = pc;
    ex_ready    = er;
    wb_regwrite = wbw;
    wb_adr_rd   = wba;
    wb_din_rd   = wbd;
    flush       = fl;
    #1;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD4  = 32'h0031_8233;  // add  x4,x3,x3
  localparam logic [31:0] I_ADD7  = 32'h0000_03B3;  // add  x7,x0,x0
  localparam logic [31:0] I_LW5   = 32'h0001_2283;  // lw   x5,0(x2)
  localparam logic [31:0] I_ADD6  = 32'h0012_8333;  // add  x6,x5,x1
  localparam logic [31:0] I_LUI8  = 32'h0002_8437;  // lui  x8 (rs1 field = 5)
  localparam logic [31:0] I_ADDI9 = 32'h0010_0493;  // addi x9,x0,1
  localparam logic [31:0] I_SW    = 32'h0011_2223;  // sw   x1,4(x2)
  localparam logic [31:0] I_ADDIA = 32'h0010_0513;  // addi x10,x0,1
  localparam logic [31:0] I_ADDIB = 32'h0010_0593;  // addi x11,x0,1
  localparam logic [31:0] I_ADDIC = 32'h0010_0613;  // addi x12,x0,1
  localparam logic [31:0] I_BEQ   = 32'h0062_8063;  // beq  x5,x6,0
  localparam logic [31:0] I_JAL   = 32'h0002_80EF;  // jal  x1 (rs1 field = 5)
  localparam logic [31:0] I_JALR  = 32'h0002_8167;  // jalr x2,0(x5)

  logic [31:0] prog [8];

  initial begin
    rst_n = 1'b0;
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_ex_valid", 32'(ex_valid), 32'h0);
    chk("reset_ex_instr", ex_instr, 32'h0000_0013);
    chk("reset_ex_rd", 32'(ex_rd), 32'h0);
    clk1();

    // First instruction after reset, one-cycle latency.
    apply(1'b1, I_ADDI1, 32'h100, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("first_if_ready", 32'(if_ready), 32'h1);
    clk1();
    chk("first_ex_valid", 32'(ex_valid), 32'h1);
    chk("first_ex_instr", ex_instr, I_ADDI1);
    chk("first_ex_pc", ex_pc, 32'h100);
    chk("first_ex_rd", 32'(ex_rd), 32'd1);
    chk("first_ex_rs1", ex_rs1_val, 32'h0);

    // WB writes x3 while ADD x4,x3,x3 is in ID.
    apply(1'b1, I_ADD4, 32'h104, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
`ifdef ID_WB_BYPASS_EN
    chk("byp_if_ready", 32'(if_ready), 32'h1);
    clk1();
`else
    chk("nobyp_stall", 32'(if_ready), 32'h0);
    clk1();
    chk("nobyp_bubble", 32'(ex_valid), 32'h0);
    apply(1'b1, I_ADD4, 32'h104, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("nobyp_if_ready", 32'(if_ready), 32'h1);
    clk1();
`endif
    chk("byp_rs1", ex_rs1_val, 32'hDEAD_BEEF);
    chk("byp_rs2", ex_rs2_val, 32'hDEAD_BEEF);
    chk("byp_rd", 32'(ex_rd), 32'd4);

    // WB to x0 must not leak into x0 reads.
    apply(1'b1, I_ADD7, 32'h108, 1'b1, 1'b1, 5'd0, 32'h55, 1'b0);
    chk("x0_if_ready", 32'(if_ready), 32'h1);
    clk1();
    chk("x0_rs1", ex_rs1_val, 32'h0);
    chk("x0_rs2", ex_rs2_val, 32'h0);
    chk("x0_rd", 32'(ex_rd), 32'd7);

    // Load-use: one bubble, then the dependent ADD.
    apply(1'b1, I_LW5, 32'h10C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    apply(1'b1, I_ADD6, 32'h110, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("luse_stall", 32'(if_ready), 32'h0);
    clk1();
    chk("luse_bubble", 32'(ex_valid), 32'h0);
    chk("luse_release", 32'(if_ready), 32'h1);
    clk1();
    chk("luse_ex_instr", ex_instr, I_ADD6);
    chk("luse_rs1", ex_rs1_val, 32'h0505_0505);
    chk("luse_rs2", ex_rs2_val, 32'h0101_0101);

    // LUI's rs1 field matching the load rd is not a hazard.
    apply(1'b1, I_LW5, 32'h114, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    apply(1'b1, I_LUI8, 32'h118, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lui_no_stall", 32'(if_ready), 32'h1);
    clk1();
    chk("lui_ex_instr", ex_instr, I_LUI8);
    chk("lui_ex_rd", 32'(ex_rd), 32'd8);

    // Back-pressure for three cycles, then back-to-back transfers.
    apply(1'b1, I_ADDI9, 32'h11C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    apply(1'b1, I_SW, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_if_ready", 32'(if_ready), 32'h0);
      clk1();
      chk("bp_ex_valid", 32'(ex_valid), 32'h1);
      chk("bp_ex_instr", ex_instr, I_ADDI9);
    end
    apply(1'b1, I_SW, 32'h120, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("bp_release", 32'(if_ready), 32'h1);
    clk1();
    chk("sw_ex_instr", ex_instr, I_SW);
    chk("sw_ex_rd", 32'(ex_rd), 32'h0);
    apply(1'b1, I_ADDIA, 32'h124, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    chk("b2b_ex_instr", ex_instr, I_ADDIA);
    chk("b2b_ex_rd", 32'(ex_rd), 32'd10);

    // Flush beats accept.
    apply(1'b1, I_ADDIB, 32'h128, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("flush_if_ready", 32'(if_ready), 32'h0);
    clk1();
    chk("flush_ex_valid", 32'(ex_valid), 32'h0);
    chk("flush_ex_instr", ex_instr, I_ADDIA);

    // Flush beats back-pressure.
    apply(1'b1, I_ADDIC, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    apply(1'b1, I_ADDIB, 32'h130, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    clk1();
    chk("flush_bp_ex_valid", 32'(ex_valid), 32'h0);

    // Load-use stall held under back-pressure keeps ex_* frozen.
    apply(1'b1, I_LW5, 32'h134, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    apply(1'b1, I_ADD6, 32'h138, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("hold_if_ready", 32'(if_ready), 32'h0);
      clk1();
      chk("hold_ex_instr", ex_instr, I_LW5);
      chk("hold_ex_valid", 32'(ex_valid), 32'h1);
    end
    apply(1'b1, I_ADD6, 32'h138, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    chk("hold_bubble", 32'(ex_valid), 32'h0);
    clk1();
    chk("hold_ex_pc", ex_pc, 32'h138);

    // Asynchronous reset while the stage holds a valid instruction.
    apply(1'b1, I_ADDIC, 32'h13C, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 32'(ex_valid), 32'h0);
    chk("arst_ex_instr", ex_instr, 32'h0000_0013);
    chk("arst_ex_pc", ex_pc, 32'h0);
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    clk1();
    rst_n = 1'b1;
    clk1();

    // Mixed stream, checked against the model every cycle.
    prog[0] = I_ADDI1; prog[1] = I_ADD4; prog[2] = I_LW5;  prog[3] = I_ADD6;
    prog[4] = I_LUI8;  prog[5] = I_BEQ;  prog[6] = I_JAL;  prog[7] = I_JALR;
    for (int k = 0; k < 120; k++) begin
      apply($urandom_range(0, 3) != 0, prog[$urandom_range(0, 7)],
            32'h2000 + 32'(k * 4), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 15) == 0);
      clk1();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
